// File: rtl/debug_seq_gen_pkg.sv
// Shared constants, state encoding and the message byte lookup for the
// debug byte-sequence generator.
package debug_seq_gen_pkg;

  localparam logic [7:0] DBG_PREFIX [5] = '{8'h44, 8'h42, 8'h47, 8'h3A, 8'h20};
  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  typedef enum logic [1:0] {IDLE, SEND, GAP, MSG_END} dbg_state_t;

  // Byte idx of the frame "DBG: " + n counter bytes from base + CR LF.
  function automatic logic [7:0] dbg_byte(input logic [8:0] idx, input logic [7:0] base,
                                          input logic [8:0] n);
    logic [2:0] p;
    p = idx[2:0];
    if (idx < 9'd5)               return DBG_PREFIX[p];
    else if (idx < n + 9'd5)      return base + idx[7:0] - 8'd5;
    else if (idx == n + 9'd5)     return CR;
    else                          return LF;
  endfunction

endpackage

// File: rtl/debug_seq_gen_debounce.sv
// Two-flop synchroniser plus counting debouncer; rise_o pulses for one
// cycle after the stable level goes high.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic resetb_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q, level_q, rise_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      // Any cycle that agrees with the stable level restarts the count.
      if (sync2_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/debug_seq_gen.sv
// Debug message generator: debounced trigger starts a framed byte stream
// paced by valid/ready, with inter-byte gap, repeat mode and stall timeout.
module debug_seq_gen
  import debug_seq_gen_pkg::*;
#(
  parameter int N_COUNT         = 16,
  parameter int GAP_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES  = 4096,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       resetb_i,
  input  logic       trig_raw_i,
  input  logic       repeat_en_i,
  input  logic [7:0] count_base_i,
  input  logic       tx_ready_i,
  output logic       tx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);
  localparam int TOTAL = N_COUNT + 7;
  localparam int IW    = $clog2(TOTAL);
  localparam int GW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int SW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(TOTAL - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    NC         = 9'(N_COUNT);

  logic trig_level, trig_rise, trig_start;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk_i    (clk_i),
    .resetb_i (resetb_i),
    .din_i    (trig_raw_i),
    .level_o  (trig_level),
    .rise_o   (trig_rise)
  );

  assign trig_start = trig_rise & trig_level;

  dbg_state_t    state_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic [SW-1:0] stall_q;
  logic [7:0]    base_q, data_q;
  logic          valid_q, busy_q, done_q, err_q;
  logic          xfer;

  assign xfer = valid_q & tx_ready_i;

  always_ff @(posedge clk_i) begin
    if (!resetb_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      stall_q <= '0;
      base_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (trig_start) begin
          base_q  <= count_base_i;
          idx_q   <= '0;
          stall_q <= '0;
          err_q   <= 1'b0;
          data_q  <= dbg_byte(9'd0, count_base_i, NC);
          valid_q <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= SEND;
        end
        SEND: if (xfer) begin
          stall_q <= '0;
          if (idx_q == IDX_LAST) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MSG_END;
          end else begin
            idx_q <= idx_q + IW'(1);
            if (GAP_CYCLES == 0) begin
              data_q <= dbg_byte(9'(idx_q) + 9'd1, base_q, NC);
            end else begin
              valid_q <= 1'b0;
              gap_q   <= '0;
              state_q <= GAP;
            end
          end
        end else if (stall_q == STALL_LAST) begin
          // Abort silently: no done pulse, err stays until next trigger.
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else begin
          stall_q <= stall_q + SW'(1);
        end
        GAP: if (gap_q == GAP_LAST) begin
          valid_q <= 1'b1;
          data_q  <= dbg_byte(9'(idx_q), base_q, NC);
          stall_q <= '0;
          state_q <= SEND;
        end else begin
          gap_q <= gap_q + GW'(1);
        end
        MSG_END: if (repeat_en_i) begin
          base_q  <= count_base_i;
          idx_q   <= '0;
          stall_q <= '0;
          if (GAP_CYCLES == 0) begin
            valid_q <= 1'b1;
            data_q  <= dbg_byte(9'd0, count_base_i, NC);
            state_q <= SEND;
          end else begin
            gap_q   <= '0;
            state_q <= GAP;
          end
        end else begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_valid_o = valid_q;
  assign tx_data_o  = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule
